// File: rtl/sinc_step_counter.sv
// Registered signed step counter: adds/subtracts a runtime step each enabled edge,
// with parameter-selected wrap or saturate on overflow, synchronous load and zero flag.
module sinc_step_counter #(
    parameter int DATAWIDTH = 32,
    parameter int STEPWIDTH = 8,
    parameter int SATURATE  = 0
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 ld,
    input  logic [DATAWIDTH-1:0] ld_val,
    input  logic                 en,
    input  logic                 dir,
    input  logic [STEPWIDTH-1:0] step,
    output logic [DATAWIDTH-1:0] d,
    output logic                 ovf,
    output logic                 zero
);

    localparam logic [DATAWIDTH-1:0] MAX_VAL = {1'b0, {(DATAWIDTH-1){1'b1}}};
    localparam logic [DATAWIDTH-1:0] MIN_VAL = {1'b1, {(DATAWIDTH-1){1'b0}}};

    logic [DATAWIDTH:0]   d_ext;
    logic [DATAWIDTH:0]   step_ext;
    logic [DATAWIDTH:0]   r;
    logic                 out_of_range;
    logic [DATAWIDTH-1:0] d_nxt;
    logic                 ovf_nxt;

    always_comb begin
        d_ext    = {d[DATAWIDTH-1], d};
        step_ext = {{(DATAWIDTH+1-STEPWIDTH){1'b0}}, step};
        r        = dir ? (d_ext - step_ext) : (d_ext + step_ext);
        // One guard bit: the result fits iff the top two bits agree.
        out_of_range = r[DATAWIDTH] ^ r[DATAWIDTH-1];
    end

    always_comb begin
        d_nxt   = d;
        ovf_nxt = 1'b0;
        if (ld) begin
            d_nxt = ld_val;
        end else if (en) begin
            d_nxt = r[DATAWIDTH-1:0];
            if (out_of_range) begin
                ovf_nxt = 1'b1;
                // Guard bit holds the true sign: 0 means upward overflow.
                if (SATURATE != 0) begin
                    d_nxt = r[DATAWIDTH] ? MIN_VAL : MAX_VAL;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            d    <= '0;
            ovf  <= 1'b0;
            zero <= 1'b1;
        end else begin
            d    <= d_nxt;
            ovf  <= ovf_nxt;
            zero <= (d_nxt == '0);
        end
    end

endmodule

// File: tb/tb_sinc_step_counter.sv
// Bench for sinc_step_counter: wrap and saturate 8-bit instances driven by one
// stimulus stream, checked against an integer-arithmetic model and directed values.
module tb_sinc_step_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ld = 1'b0;
    logic [7:0] ld_val = '0;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic [6:0] step = '0;
    logic [7:0] d_w, d_s;
    logic       ovf_w, ovf_s, zero_w, zero_s;

    int checks = 0;
    int failures = 0;

    int m_d_w = 0, m_d_s = 0;
    bit m_o_w = 0, m_o_s = 0, m_z_w = 1, m_z_s = 1;

    always #5 clk = ~clk;

    sinc_step_counter #(.DATAWIDTH(8), .STEPWIDTH(7), .SATURATE(0)) dut_w (
        .Clk(clk), .Rst(rst), .ld(ld), .ld_val(ld_val), .en(en), .dir(dir),
        .step(step), .d(d_w), .ovf(ovf_w), .zero(zero_w)
    );

    sinc_step_counter #(.DATAWIDTH(8), .STEPWIDTH(7), .SATURATE(1)) dut_s (
        .Clk(clk), .Rst(rst), .ld(ld), .ld_val(ld_val), .en(en), .dir(dir),
        .step(step), .d(d_s), .ovf(ovf_s), .zero(zero_s)
    );

    // Signed 8-bit counting in plain integers.
    function automatic int model_next(input int cur, input bit sat, output bit o);
        int r;
        r = dir ? cur - int'(step) : cur + int'(step);
        o = 1'b0;
        if (r > 127 || r < -128) begin
            o = 1'b1;
            if (sat) r = (r > 127) ? 127 : -128;
            else     r = (((r + 128) % 256 + 256) % 256) - 128;
        end
        return r;
    endfunction

    task automatic model_update();
        bit ow, os;
        if (rst) begin
            m_d_w = 0; m_d_s = 0; m_o_w = 0; m_o_s = 0;
        end else if (ld) begin
            m_d_w = int'($signed(ld_val)); m_d_s = m_d_w; m_o_w = 0; m_o_s = 0;
        end else if (en) begin
            m_d_w = model_next(m_d_w, 1'b0, ow);
            m_d_s = model_next(m_d_s, 1'b1, os);
            m_o_w = ow; m_o_s = os;
        end else begin
            m_o_w = 0; m_o_s = 0;
        end
        m_z_w = (m_d_w == 0);
        m_z_s = (m_d_s == 0);
    endtask

    task automatic cmp(input string tag, input logic [7:0] od, input logic oo, input logic oz,
                       input int ed, input bit eo, input bit ez);
        logic [7:0] edv;
        edv = 8'(ed);
        checks++;
        assert (od === edv && oo === eo && oz === ez)
        else begin
            failures++;
            $error("FAIL %s: got d=%0d ovf=%b zero=%b, expected d=%0d ovf=%b zero=%b",
                   tag, $signed(od), oo, oz, $signed(edv), eo, ez);
        end
    endtask

    // Advance one edge, update the model, compare both instances to it.
    task automatic tick(input string tag);
        @(posedge clk);
        model_update();
        #1;
        cmp({tag, "/wrap"}, d_w, ovf_w, zero_w, m_d_w, m_o_w, m_z_w);
        cmp({tag, "/sat"},  d_s, ovf_s, zero_s, m_d_s, m_o_s, m_z_s);
    endtask

    task automatic set_in(input bit r, input bit l, input int lv, input bit e,
                          input bit dr, input int st);
        rst = r; ld = l; ld_val = 8'(lv); en = e; dir = dr; step = 7'(st);
    endtask

    initial begin
        // Reset dominates ld and en
        set_in(1, 1, 55, 1, 0, 3);
        tick("reset");
        cmp("reset_const_w", d_w, ovf_w, zero_w, 0, 0, 1);
        cmp("reset_const_s", d_s, ovf_s, zero_s, 0, 0, 1);

        // Wrap across +127
        set_in(0, 1, 125, 0, 0, 0); tick("ld125");
        set_in(0, 0, 0, 1, 0, 1);
        tick("up1_a"); cmp("wrap_126", d_w, ovf_w, zero_w, 126, 0, 0);
        tick("up1_b"); cmp("wrap_127", d_w, ovf_w, zero_w, 127, 0, 0);
        tick("up1_c"); cmp("wrap_m128", d_w, ovf_w, zero_w, -128, 1, 0);
        cmp("sat_top", d_s, ovf_s, zero_s, 127, 1, 0);

        // Saturate at -128, repeated overflow pulses
        set_in(0, 1, -126, 0, 0, 0); tick("ldm126");
        set_in(0, 0, 0, 1, 1, 5);
        tick("dn5_a"); cmp("sat_m128_a", d_s, ovf_s, zero_s, -128, 1, 0);
        tick("dn5_b"); cmp("sat_m128_b", d_s, ovf_s, zero_s, -128, 1, 0);
        set_in(0, 0, 0, 1, 0, 3);
        tick("up3"); cmp("sat_m125", d_s, ovf_s, zero_s, -125, 0, 0);

        // Load priority over en
        set_in(0, 1, -7, 1, 0, 4);
        tick("ld_prio"); cmp("ld_prio", d_s, ovf_s, zero_s, -7, 0, 0);
        set_in(0, 0, 0, 1, 0, 4);
        tick("after_ld"); cmp("after_ld", d_w, ovf_w, zero_w, -3, 0, 0);

        // Zero flag, hold, zero step
        set_in(0, 1, 3, 0, 0, 0); tick("ld3");
        set_in(0, 0, 0, 1, 1, 3);
        tick("to_zero"); cmp("to_zero", d_w, ovf_w, zero_w, 0, 0, 1);
        set_in(0, 0, 0, 0, 1, 3);
        tick("hold_a"); tick("hold_b"); cmp("hold", d_w, ovf_w, zero_w, 0, 0, 1);
        set_in(0, 0, 0, 1, 0, 0);
        tick("step0"); cmp("step0", d_s, ovf_s, zero_s, 0, 0, 1);

        // Large step
        set_in(0, 1, 100, 0, 0, 0); tick("ld100");
        set_in(0, 0, 0, 1, 0, 127);
        tick("big"); cmp("big_wrap", d_w, ovf_w, zero_w, -29, 1, 0);
        cmp("big_sat", d_s, ovf_s, zero_s, 127, 1, 0);

        // Reset mid-count, then resume from 0
        set_in(1, 0, 0, 1, 0, 9); tick("mid_rst");
        set_in(0, 0, 0, 1, 0, 9);
        tick("resume"); cmp("resume", d_w, ovf_w, zero_w, 9, 0, 0);

        // Randomized traffic, rail-biased loads
        for (int i = 0; i < 400; i++) begin
            int lv;
            lv = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) != 0) ? 120 + int'($urandom_range(0, 7))
                                                                            : -128 + int'($urandom_range(0, 7)))
                                             : int'($urandom_range(0, 255)) - 128;
            set_in($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0, lv,
                   $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                   ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 127)));
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sinc_step_counter.md
# sinc_step_counter

Parametrised signed step counter; registered successor to the combinational signed-increment datapath component. Holds a signed DATAWIDTH-bit value and, on each enabled clock edge, adds or subtracts a runtime step, with a parameter-selected wrap or saturate policy. Provides synchronous load, an overflow pulse and a zero flag. Used in scheduled datapaths wherever a loop index or accumulator increments by more than one, or must count down.

## Interface

- DATAWIDTH, 32, width of the signed count value d and load value
- STEPWIDTH, 8, width of the unsigned step magnitude; legal range 1 to DATAWIDTH-1
- SATURATE, 0, overflow policy: 0 = two's-complement wrap, 1 = clamp to min/max

- Clk  input  1  clock, rising edge; the only clock
- Rst  input  1  synchronous, active-high reset
- ld  input  1  load ld_val into d on next edge
- ld_val  input  DATAWIDTH  signed load value
- en  input  1  count enable
- dir  input  1  0 = count up (d + step), 1 = count down (d - step)
- step  input  STEPWIDTH  unsigned step magnitude, zero-extended
- d  output  DATAWIDTH  signed count, registered
- ovf  output  1  registered one-cycle pulse: last update overflowed
- zero  output  1  registered, high when d == 0

## Operation

- Priority on each rising Clk edge: Rst > ld > en > hold.
- Rst: d = 0, ovf = 0, zero = 1.
- ld (Rst low): d = ld_val, ovf = 0, zero = (ld_val == 0). en, dir and step are ignored.
- en (Rst, ld low): form a DATAWIDTH+1-bit signed result r = sign-extended d ± zero-extended step.
  - r within [-2^(DATAWIDTH-1), 2^(DATAWIDTH-1)-1]: d = r, ovf = 0.
  - r out of range, SATURATE=0: d = low DATAWIDTH bits of r (wrap), ovf = 1.
  - r out of range, SATURATE=1: d = max on an upward overflow, or min on a downward overflow; ovf = 1.
- Hold (all low): d unchanged, ovf = 0, zero unchanged.
- step = 0 with en high: d unchanged, ovf = 0.
- ovf is a pulse. It reasserts on every consecutive overflowing update, including repeated saturated updates that leave d at the rail.
- zero is computed from the next value of d and registered with it. It is never decoded combinationally from d.
- No internal state beyond d, ovf and zero. There is no FSM; the mode is fixed by parameter.

## Timing

- Latency: 1 cycle. Inputs sampled at edge N are reflected in d, ovf and zero after edge N.
- All outputs change only on a rising Clk edge, and all three update on the same edge.
- No combinational path from any input to any output.
- Reset mid-count: the edge with Rst high forces the reset values regardless of ld and en. Counting resumes on the first edge after Rst falls, from 0.
- Reset values: d = 0, ovf = 0, zero = 1.
- en may be held high continuously; one update per cycle, no back-pressure.

## Test plan

- Reset: Rst=1 with ld=1, ld_val=55, en=1 for one edge -> d=0, ovf=0, zero=1.
- Wrap (DATAWIDTH=8, SATURATE=0): load 125, then en=1, dir=0, step=1 for 3 edges -> d = 126, 127, -128; ovf=0, 0, 1.
- Saturate (DATAWIDTH=8, SATURATE=1): load -126, then en=1, dir=1, step=5 for 2 edges -> d = -128, -128; ovf = 1, 1. Then dir=0, step=3 -> d=-125, ovf=0.
- Load priority: ld=1, ld_val=-7, en=1, dir=0, step=4 -> d=-7, ovf=0, zero=0. Next edge with ld=0, en=1 -> d=-3.
- Zero flag and hold: load 3, then en=1, dir=1, step=3 -> d=0, zero=1. Then en=0 for 2 edges -> d=0, zero=1, ovf=0. Then en=1, step=0 -> d=0, ovf=0.
- Large step (DATAWIDTH=8, STEPWIDTH=7, SATURATE=0): load 100, then en=1, dir=0, step=127 -> d=-29, ovf=1.
